// File: rtl/cart_rom_fetch.sv
// Cartridge ROM fetch arbiter: merges CPU PRG and PPU CHR reads onto one external ROM port.
// Optional build macro PPU_PRIORITY_EN selects fixed CHR priority instead of round-robin.
module cart_rom_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  game,
  input  logic        prg_req,
  input  logic [14:0] prg_addr,
  output logic        prg_ack,
  output logic [7:0]  prg_data,
  input  logic        chr_req,
  input  logic [12:0] chr_addr,
  output logic        chr_ack,
  output logic [7:0]  chr_data,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT_PRG, WAIT_CHR, DONE} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic [7:0]  prg_data_q, prg_data_d;
  logic [7:0]  chr_data_q, chr_data_d;
  logic        gnt_chr_q, gnt_chr_d;
  logic        grant_chr;
`ifndef PPU_PRIORITY_EN
  logic        prefer_chr_q, prefer_chr_d;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    prg_data_d = prg_data_q;
    chr_data_d = chr_data_q;
    gnt_chr_d  = gnt_chr_q;
`ifdef PPU_PRIORITY_EN
    grant_chr    = chr_req;
`else
    prefer_chr_d = prefer_chr_q;
    grant_chr    = chr_req && (!prg_req || prefer_chr_q);
`endif
    case (state_q)
      IDLE: begin
        if (prg_req || chr_req) begin
          gnt_chr_d  = grant_chr;
          mem_req_d  = 1'b1;
          mem_addr_d = grant_chr ? {game, 3'b100, chr_addr} : {game, 1'b0, prg_addr};
          state_d    = grant_chr ? WAIT_CHR : WAIT_PRG;
`ifndef PPU_PRIORITY_EN
          // The client just served loses the next tie.
          prefer_chr_d = !grant_chr;
`endif
        end
      end
      WAIT_PRG: begin
        if (mem_ack) begin
          prg_data_d = mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = DONE;
        end
      end
      WAIT_CHR: begin
        if (mem_ack) begin
          chr_data_d = mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      prg_data_q <= '0;
      chr_data_q <= '0;
      gnt_chr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      prg_data_q <= prg_data_d;
      chr_data_q <= chr_data_d;
      gnt_chr_q  <= gnt_chr_d;
    end
  end

`ifndef PPU_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prefer_chr_q <= 1'b0;
    else        prefer_chr_q <= prefer_chr_d;
  end
`endif

  assign prg_ack  = (state_q == DONE) && !gnt_chr_q;
  assign chr_ack  = (state_q == DONE) &&  gnt_chr_q;
  assign prg_data = prg_data_q;
  assign chr_data = chr_data_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Self-checking bench for cart_rom_fetch: transaction-level model compared every cycle,
// plus directed literal checks for addresses, latency, arbitration order and reset abort.
module tb_cart_rom_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  game = '0;
  logic        prg_req = 1'b0;
  logic [14:0] prg_addr = '0;
  logic        prg_ack;
  logic [7:0]  prg_data;
  logic        chr_req = 1'b0;
  logic [12:0] chr_addr = '0;
  logic        chr_ack;
  logic [7:0]  chr_data;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  cart_rom_fetch dut (
    .clk(clk), .rst_n(rst_n), .game(game),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_ack(prg_ack), .prg_data(prg_data),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_ack(chr_ack), .chr_data(chr_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, ack one cycle after completion.
  logic        m_busy, m_chr, m_ackcyc, m_pack, m_cack, m_ptr_chr;
  logic [19:0] m_addr;
  logic [7:0]  m_pdata, m_cdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_chr <= 1'b0; m_ackcyc <= 1'b0; m_pack <= 1'b0; m_cack <= 1'b0;
      m_ptr_chr <= 1'b0; m_addr <= '0; m_pdata <= '0; m_cdata <= '0;
    end else begin
      m_pack <= 1'b0;
      m_cack <= 1'b0;
      if (m_ackcyc) begin
        m_ackcyc <= 1'b0;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_busy <= 1'b0;
          m_ackcyc <= 1'b1;
          if (m_chr) begin m_cdata <= mem_rdata; m_cack <= 1'b1; end
          else       begin m_pdata <= mem_rdata; m_pack <= 1'b1; end
        end
      end else if (prg_req || chr_req) begin
        logic pick_chr;
`ifdef PPU_PRIORITY_EN
        pick_chr = chr_req;
`else
        pick_chr = chr_req && !(prg_req && !m_ptr_chr);
`endif
        m_busy <= 1'b1;
        m_chr <= pick_chr;
        m_ptr_chr <= !pick_chr;
        if (pick_chr) m_addr <= 20'(int'(game) * 65536 + 32768 + int'(chr_addr));
        else          m_addr <= 20'(int'(game) * 65536 + int'(prg_addr));
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_mem_req", {31'd0, mem_req}, {31'd0, m_busy});
    chk("mdl_mem_addr", {12'd0, mem_addr}, {12'd0, m_addr});
    chk("mdl_prg_ack", {31'd0, prg_ack}, {31'd0, m_pack});
    chk("mdl_chr_ack", {31'd0, chr_ack}, {31'd0, m_cack});
    chk("mdl_prg_data", {24'd0, prg_data}, {24'd0, m_pdata});
    chk("mdl_chr_data", {24'd0, chr_data}, {24'd0, m_cdata});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for mem_req, inserts wait states, then pulses mem_ack.
  // Returns in the client-ack cycle.
  task automatic serve(input int unsigned dly, input logic [7:0] rd);
    int unsigned t;
    logic [19:0] a0;
    t = 0;
    while (!mem_req && t < 20) begin tick; t++; end
    if (!mem_req) chk("mem_req_timeout", 32'd0, 32'd1);
    a0 = mem_addr;
    for (int unsigned i = 0; i < dly; i++) begin
      chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
      chk("wait_mem_addr", {12'd0, mem_addr}, {12'd0, a0});
      tick;
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick;
    mem_ack = 1'b0;
  endtask

  initial begin
    logic exp_chr [4];
    tick; tick;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
    chk("rst_acks", {30'd0, prg_ack, chr_ack}, 32'd0);
    chk("rst_data", {16'd0, prg_data, chr_data}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single PRG read, zero-wait memory: ack two cycles after request.
    game = 4'd2; prg_addr = 15'h1234; prg_req = 1'b1;
    tick;
    chk("prg_mem_req", {31'd0, mem_req}, 32'd1);
    chk("prg_mem_addr", {12'd0, mem_addr}, 32'h21234);
    chk("prg_early_ack", {31'd0, prg_ack}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick;
    mem_ack = 1'b0;
    chk("prg_ack", {31'd0, prg_ack}, 32'd1);
    chk("prg_data", {24'd0, prg_data}, 32'hA5);
    chk("prg_chr_ack", {31'd0, chr_ack}, 32'd0);
    chk("prg_mem_req_drop", {31'd0, mem_req}, 32'd0);
    prg_req = 1'b0;
    tick;
    chk("prg_ack_pulse", {31'd0, prg_ack}, 32'd0);

    // Single CHR read at top of window.
    game = 4'd7; chr_addr = 13'h1FFF; chr_req = 1'b1;
    tick;
    chk("chr_mem_addr", {12'd0, mem_addr}, 32'h79FFF);
    serve(0, 8'h3C);
    chr_req = 1'b0;
    chk("chr_ack", {31'd0, chr_ack}, 32'd1);
    chk("chr_data", {24'd0, chr_data}, 32'h3C);
    chk("chr_prg_kept", {24'd0, prg_data}, 32'hA5);
    tick; tick;

    // Wait states with a game change mid-access, then a spurious mem_ack.
    game = 4'd5; chr_addr = 13'h00AB; chr_req = 1'b1;
    tick;
    game = 4'd9;
    chk("ws_mem_addr", {12'd0, mem_addr}, 32'h580AB);
    serve(10, 8'h77);
    chr_req = 1'b0;
    chk("ws_chr_ack", {31'd0, chr_ack}, 32'd1);
    chk("ws_chr_data", {24'd0, chr_data}, 32'h77);
    tick; tick;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick;
    mem_ack = 1'b0;
    chk("spur_mem_req", {31'd0, mem_req}, 32'd0);
    tick;
    chk("spur_acks", {30'd0, prg_ack, chr_ack}, 32'd0);
    chk("spur_data", {16'd0, prg_data, chr_data}, 32'hA577);

    // Reset in the middle of a PRG wait.
    game = 4'd3; prg_addr = 15'h0100; prg_req = 1'b1;
    tick; tick;
    chk("ra_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0; prg_req = 1'b0;
    #1;
    chk("ra_mem_req_clr", {31'd0, mem_req}, 32'd0);
    chk("ra_mem_addr_clr", {12'd0, mem_addr}, 32'd0);
    chk("ra_prg_ack", {31'd0, prg_ack}, 32'd0);
    chk("ra_data_clr", {16'd0, prg_data, chr_data}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk_no_ack: chk("ra_no_late_ack", {30'd0, prg_ack, chr_ack}, 32'd0);
    chr_addr = 13'h0042; chr_req = 1'b1;
    serve(1, 8'h5A);
    chr_req = 1'b0;
    chk("ra_fresh_ack", {31'd0, chr_ack}, 32'd1);
    chk("ra_fresh_data", {24'd0, chr_data}, 32'h5A);
    tick; tick;

    // Simultaneous requests held across four rounds (last served was CHR).
`ifdef PPU_PRIORITY_EN
    exp_chr = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_chr = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    game = 4'd1; prg_addr = 15'h0010; chr_addr = 13'h0020;
    prg_req = 1'b1; chr_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      serve(0, 8'(8'h10 + r));
      if (r == 3) begin prg_req = 1'b0; chr_req = 1'b0; end
      chk($sformatf("rr_round%0d_chr", r), {31'd0, chr_ack}, {31'd0, exp_chr[r]});
      chk($sformatf("rr_round%0d_prg", r), {31'd0, prg_ack}, {31'd0, !exp_chr[r]});
      tick;
    end
    tick; tick;
    chk("final_idle", {31'd0, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
